// File: rtl/fft_window_ctrl_pkg.sv
// Shared types and helpers for the FFT window frame sequencer.
package fft_window_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_LOG2_DEF = 4;
  localparam int unsigned MAX_LOG2_DEF = 10;

  function automatic logic [3:0] clamp_log2(input logic [3:0]  req,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (32'(req) < lo) return 4'(lo);
    if (32'(req) > hi) return 4'(hi);
    return req;
  endfunction

endpackage

// File: rtl/fft_window_ctrl_if.sv
// Sample stream into and out of the window controller.
interface fft_window_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] tdata_s;
  logic          tvalid_s;
  logic          tready_s;
  logic [DW-1:0] tdata_m;
  logic          tvalid_m;
  logic          tlast_m;
  logic          tready_m;

  modport slave (
    input  tdata_s, tvalid_s, tready_m,
    output tready_s, tdata_m, tvalid_m, tlast_m
  );

  modport master (
    output tdata_s, tvalid_s, tready_m,
    input  tready_s, tdata_m, tvalid_m, tlast_m
  );
endinterface

// File: rtl/fft_window_ctrl.sv
// Frames the sample stream into 2^N-sample blocks, drives the coefficient read
// index and schedules double-buffered coefficient bank swaps at frame boundaries.
module fft_window_ctrl
  import fft_window_ctrl_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
  parameter int unsigned MIN_LOG2 = MIN_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_window_ctrl_if.slave    axis,
  input  logic [3:0]          cfg_len_log2,
  input  logic [15:0]         cfg_frames,
  input  logic                start,
  input  logic                stop,
  input  logic                wr_en,
  input  logic [MAX_LOG2-1:0] wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                swap_req,
  output logic [MAX_LOG2-1:0] coef_raddr,
  output logic                coef_rbank,
  output logic                coef_we,
  output logic [MAX_LOG2-1:0] coef_waddr,
  output logic                coef_wbank,
  output logic [DW-1:0]       coef_wdata,
  output logic                busy,
  output logic                swap_pending,
  output logic                done,
  output logic [15:0]         frame_cnt
);

  state_e              state_q;
  logic [MAX_LOG2-1:0] idx_q;
  logic [3:0]          len_q;
  logic [15:0]         frames_q;
  logic [15:0]         frame_cnt_q;
  logic [15:0]         frame_cnt_d;
  logic                bank_q;
  logic                swap_pend_q;
  logic                stop_pend_q;
  logic                done_q;

  logic                running;
  logic                beat;
  logic                last;
  logic                end_run;
  logic [MAX_LOG2-1:0] last_idx;

  assign running  = (state_q == RUN);
  assign last_idx = {MAX_LOG2{1'b1}} >> (4'(MAX_LOG2) - len_q);
  assign last     = running && (idx_q == last_idx);
  assign beat     = running && axis.tvalid_s && axis.tready_m;

  assign frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
  // A stop arriving on the tlast beat itself still ends the run at this boundary.
  assign end_run = stop_pend_q || stop ||
                   ((frames_q != '0) && (frame_cnt_d == frames_q));

  assign axis.tdata_m  = axis.tdata_s;
  assign axis.tvalid_m = running && axis.tvalid_s;
  assign axis.tready_s = running && axis.tready_m;
  assign axis.tlast_m  = last;

  assign coef_raddr   = idx_q;
  assign coef_rbank   = bank_q;
  assign coef_we      = wr_en;
  assign coef_waddr   = wr_addr;
  assign coef_wdata   = wr_data;
  assign coef_wbank   = ~bank_q;

  assign busy         = running;
  assign swap_pending = swap_pend_q;
  assign done         = done_q;
  assign frame_cnt    = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= 4'(MIN_LOG2);
      frames_q    <= '0;
      frame_cnt_q <= '0;
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (swap_req) bank_q <= ~bank_q;
          if (start) begin
            state_q     <= RUN;
            len_q       <= clamp_log2(cfg_len_log2, MIN_LOG2, MAX_LOG2);
            frames_q    <= cfg_frames;
            frame_cnt_q <= '0;
            idx_q       <= '0;
          end
        end
        RUN: begin
          if (stop)     stop_pend_q <= 1'b1;
          if (swap_req) swap_pend_q <= 1'b1;
          if (beat) begin
            if (last) begin
              idx_q       <= '0;
              frame_cnt_q <= frame_cnt_d;
              // A request landing on the applying boundary is queued for the next one.
              if (swap_pend_q) begin
                bank_q      <= ~bank_q;
                swap_pend_q <= swap_req;
              end
              if (end_run) begin
                state_q     <= IDLE;
                done_q      <= 1'b1;
                stop_pend_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_window_ctrl.sv
// Directed bench for fft_window_ctrl with a beat scoreboard and cycle-level checks.
module tb_fft_window_ctrl;
  import fft_window_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int ML = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [3:0]    cfg_len_log2 = 4'd4;
  logic [15:0]   cfg_frames = 16'd0;
  logic          start = 1'b0, stop = 1'b0, swap_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [ML-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [ML-1:0] coef_raddr, coef_waddr;
  logic          coef_rbank, coef_we, coef_wbank;
  logic [DW-1:0] coef_wdata;
  logic          busy, swap_pending, done;
  logic [15:0]   frame_cnt;

  fft_window_ctrl_if #(.DW(DW)) axis();

  fft_window_ctrl #(.DW(DW), .MAX_LOG2(ML), .MIN_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .axis(axis),
    .cfg_len_log2(cfg_len_log2), .cfg_frames(cfg_frames),
    .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
    .coef_raddr(coef_raddr), .coef_rbank(coef_rbank),
    .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wbank(coef_wbank),
    .coef_wdata(coef_wdata),
    .busy(busy), .swap_pending(swap_pending), .done(done), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  idx;
    logic        last;
    logic        bank;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // Reference model state (reflects DUT registers after the most recent edge)
  bit          m_run = 0, m_bank = 0, m_pend = 0, m_stp = 0, m_done = 0;
  int          m_idx = 0, m_len = 4, m_cnt = 0, m_frames = 0;
  logic [15:0] dctr = 16'h1000;

  task automatic step(input bit rst, input bit v, input bit r,
                      input bit sw, input bit stp, input bit st);
    bit beat, last, old_pend, old_stp;
    @(posedge clk);
    #1;
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("swap_pending", swap_pending, m_pend);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("coef_rbank", coef_rbank, m_bank);
    dctr = dctr + 16'd1;
    reset_n = rst; axis.tvalid_s = v; axis.tready_m = r; axis.tdata_s = dctr;
    swap_req = sw; stop = stp; start = st;
    wr_en = dctr[1]; wr_addr = dctr[9:0] ^ 10'h155; wr_data = ~dctr;
    #1;
    chk("coef_write", {coef_we, coef_waddr, coef_wdata, coef_wbank},
        {wr_en, wr_addr, wr_data, ~m_bank});
    chk("tready_s", axis.tready_s, m_run && r);
    chk("tvalid_m", axis.tvalid_m, m_run && v);
    beat = m_run && v && r;
    last = m_run && (m_idx == (1 << m_len) - 1);
    chk("tlast_m", axis.tlast_m, last);
    if (beat) sbq.push_back('{dctr, 10'(m_idx), last, m_bank});
    if (!rst) begin
      m_run = 0; m_idx = 0; m_cnt = 0; m_bank = 0;
      m_pend = 0; m_stp = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (sw) m_bank = ~m_bank;
        if (st) begin
          m_run = 1; m_idx = 0; m_cnt = 0; m_frames = int'(cfg_frames);
          m_len = (cfg_len_log2 < 4) ? 4 : (cfg_len_log2 > 10) ? 10 : int'(cfg_len_log2);
        end
      end else begin
        old_pend = m_pend; old_stp = m_stp;
        if (stp) m_stp = 1;
        if (sw) m_pend = 1;
        if (beat) begin
          if (last) begin
            m_idx = 0;
            if (m_cnt != 65535) m_cnt++;
            if (old_pend) begin m_bank = ~m_bank; m_pend = sw; end
            if (old_stp || stp || (m_frames != 0 && m_cnt == m_frames)) begin
              m_run = 0; m_done = 1; m_stp = 0;
            end
          end else m_idx++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (axis.tvalid_m && axis.tready_m) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL extra_beat got=%0h exp=none", axis.tdata_m);
      end else begin
        e = sbq.pop_front();
        chk("beat", {axis.tdata_m, coef_raddr, axis.tlast_m, coef_rbank}, e);
      end
    end
  end

  initial begin
    axis.tvalid_s = 1'b0; axis.tready_m = 1'b1; axis.tdata_s = '0;
    step(0, 0, 1, 0, 0, 0);
    chk("reset_raddr", coef_raddr, 0);
    idle(2);

    // 1: two 16-sample frames then auto-stop
    cfg_len_log2 = 4; cfg_frames = 2;
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 32; k++) begin
      step(1, 1, 1, 0, 0, 0);
      chk("t1_tlast", axis.tlast_m, (k == 15 || k == 31));
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t1_done", done, 1);
    chk("t1_frame_cnt", frame_cnt, 2);
    chk("t1_busy", busy, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("t1_done_once", done, 0);

    // 2: swap requested mid-frame, applied at the boundary
    cfg_frames = 0;
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 48; k++) begin
      step(1, 1, 1, (k == 5), (k == 32), 0);
      if (k < 32) begin
        chk("t2_pending", swap_pending, (k >= 6 && k <= 15));
        chk("t2_rbank", coef_rbank, (k >= 16));
      end
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t2_busy", busy, 0);

    // 3: swap coincident with tlast defers one frame
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 48; k++) begin
      step(1, 1, 1, (k == 15), (k == 40), 0);
      chk("t3_pending", swap_pending, (k >= 16 && k <= 31));
      chk("t3_rbank", coef_rbank, (k < 32));
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t3_busy", busy, 0);

    // swap in IDLE toggles directly
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("idle_swap_rbank", coef_rbank, 1);
    chk("idle_swap_pending", swap_pending, 0);

    // 4: alternating backpressure
    cfg_frames = 1;
    step(1, 0, 1, 0, 0, 1);
    for (int c = 0; c < 32; c++) begin
      step(1, 1, (c % 2 == 0), 0, 0, 0);
      chk("t4_tlast", axis.tlast_m, (c == 29 || c == 30));
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t4_busy", busy, 0);
    chk("t4_frame_cnt", frame_cnt, 1);

    // 5: length clamping at both ends
    cfg_len_log2 = 12;
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 1024; k++) begin
      step(1, 1, 1, 0, 0, 0);
      if (k >= 1020) chk("t5_tlast_1024", axis.tlast_m, (k == 1023));
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t5_busy_1024", busy, 0);
    cfg_len_log2 = 2;
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 1, 0, 0, 0);
      chk("t5_tlast_16", axis.tlast_m, (k == 15));
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t5_busy_16", busy, 0);

    // 6: stop mid-frame, then reset mid-frame
    cfg_len_log2 = 4; cfg_frames = 0;
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 1, 0, (k == 7), 0);
      chk("t6_busy", busy, 1);
    end
    step(1, 0, 1, 0, 0, 0);
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_done", done, 1);
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 9; k++) step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_raddr", coef_raddr, 0);
    chk("t6_rst_rbank", coef_rbank, 0);
    chk("t6_rst_tlast", axis.tlast_m, 0);
    idle(3);

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_window_ctrl.md
Name: fft_window_ctrl

Overview:
- Frame sequencer and coefficient-bank scheduler placed in front of the FFT window stage.
- Gates the sample AXI-Stream into frames of 2^N samples and generates tlast at each frame boundary.
- Drives the coefficient read index that the window stage uses.
- Owns a double-buffered coefficient RAM. The host writes the shadow bank; bank swaps are deferred to frame boundaries so that no frame mixes two windows.

Parameters:
- DW, 16, sample and coefficient width.
- MAX_LOG2, 10, maximum frame length exponent. Also sets the RAM depth to 2^MAX_LOG2 per bank.
- MIN_LOG2, 4, minimum frame length exponent.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- tdata_s  in  DW  input samples
- tvalid_s  in  1  input valid
- tready_s  out  1  input ready
- tdata_m  out  DW  samples to window
- tvalid_m  out  1  output valid
- tlast_m  out  1  last sample of frame
- tready_m  in  1  window ready
- cfg_len_log2  in  4  frame length exponent, sampled at start
- cfg_frames  in  16  frames to run; 0 = continuous
- start  in  1  pulse: begin run
- stop  in  1  pulse: end run at next frame boundary
- wr_en  in  1  host coefficient write
- wr_addr  in  MAX_LOG2  coefficient address
- wr_data  in  DW  coefficient value
- swap_req  in  1  pulse: request bank swap
- coef_raddr  out  MAX_LOG2  read index to coefficient RAM
- coef_rbank  out  1  active bank
- coef_we  out  1  RAM write enable
- coef_waddr  out  MAX_LOG2  RAM write address
- coef_wbank  out  1  shadow bank (~active)
- coef_wdata  out  DW  RAM write data
- busy  out  1  state != IDLE
- swap_pending  out  1  swap requested, not yet applied
- done  out  1  one-cycle pulse when a run ends
- frame_cnt  out  16  frames completed in current run

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - state=IDLE; idx=0; frame_cnt=0; active bank=0.
  - swap_pending=0, stop_pending=0, done=0.
  - A reset mid-frame abandons the frame; no tlast is emitted.
- States:
  - IDLE: tready_s=0, tvalid_m=0.
  - RUN: tvalid_m=tvalid_s, tready_s=tready_m, tdata_m=tdata_s (combinational pass-through, zero latency).
- Transitions:
  - IDLE -> RUN on start. In that cycle: latch len_log2 = clamp(cfg_len_log2, MIN_LOG2, MAX_LOG2), latch cfg_frames, clear frame_cnt.
  - start while in RUN is ignored.
- Beats and frames:
  - A beat is a cycle with tvalid_s && tready_m in RUN.
  - tlast_m = (idx == 2^len_log2 - 1) && state==RUN.
  - coef_raddr = idx, combinational, so the coefficient aligns with the current sample.
  - On each beat: idx increments. On a tlast beat: idx returns to 0 and frame_cnt increments, saturating at 0xFFFF.
- Frame-end actions, on the tlast beat:
  - If swap_pending: toggle the active bank and clear swap_pending; takes effect for the next beat.
  - If stop_pending, or cfg_frames != 0 and frame_cnt+1 == cfg_frames: go to IDLE, pulse done next cycle, clear stop_pending.
- stop:
  - In RUN, sets stop_pending.
  - In IDLE, ignored.
  - stop together with a tlast beat ends the run at that same boundary.
- swap_req:
  - In IDLE: the active bank toggles on the next edge; swap_pending stays 0.
  - In RUN: sets swap_pending. A second request while pending is ignored.
  - A request in the same cycle as a tlast beat becomes pending for the following boundary; it is not applied immediately.
- Host writes:
  - coef_we=wr_en, coef_waddr=wr_addr, coef_wdata=wr_data, all combinational.
  - coef_wbank = ~active bank register value in that cycle.
  - A write in the cycle a swap takes effect goes to the pre-swap shadow bank.
- Backpressure: with tready_m=0, idx and all state hold; no beats are lost or duplicated.

Decomposition:
- fft_pkg:
  - state enum (IDLE, RUN).
  - Constants MIN_LOG2 / MAX_LOG2 defaults.
  - Clamp function for len_log2.
- Sub-module fft_coef_dpram: two-bank simple dual-port RAM, instantiated beside this block rather than inside it.
- The controller itself stays a single module.

Test Plan:
1. len_log2=4, frames=2, start, continuous valid, tready_m=1 -> tlast_m on beats 15 and 31; done pulses 1 cycle after beat 31; frame_cnt=2; busy drops.
2. len_log2=4, continuous; swap_req at beat 5 -> coef_rbank=0 through beat 15, =1 from beat 16; swap_pending high from beat 6 until the cycle after beat 15.
3. swap_req coincident with beat 15 -> no swap at beat 16; swap applied after beat 31.
4. tready_m toggled 1/0 every cycle through a 16-sample frame -> coef_raddr sequence 0..15 with no gaps; tlast only on the 16th beat.
5. cfg_len_log2=12 -> frame length 1024; cfg_len_log2=2 -> frame length 16.
6. stop at beat 7 of continuous run -> IDLE after beat 15. Separately, reset_n=0 at beat 9 -> next cycle busy=0, idx=0, coef_rbank=0.
